// File: rtl/anton_neopixel_pixel_serializer_pkg.sv
// Shared types and defaults for the NeoPixel pixel serializer: fetch FSM
// state encodings, default bit-timing tick counts and a pixel bit selector.
package anton_neopixel_pixel_serializer_pkg;

    localparam int BUFFER_END_DEFAULT = 1023;
    localparam int T0H_TICKS_DEFAULT  = 3;
    localparam int T1H_TICKS_DEFAULT  = 6;

    typedef enum logic [2:0] {
        FETCH_IDLE = 3'd0,
        FETCH_RD0  = 3'd1,
        FETCH_RD1  = 3'd2,
        FETCH_RD2  = 3'd3,
        FETCH_DONE = 3'd4
    } fetchState_e;

    // Bit bitIndex of a GRB word, counted MSB first; out-of-range indexes read as 0.
    function automatic logic pixelBitAt(input logic [23:0] pixel, input logic [4:0] bitIndex);
        logic bitVal;
        if (bitIndex <= 5'd23) begin
            bitVal = pixel[5'd23 - bitIndex];
        end else begin
            bitVal = 1'b0;
        end
        return bitVal;
    endfunction

endpackage

// File: rtl/anton_neopixel_rgb332_expand.sv
// Combinational RGB332 -> 24-bit GRB expansion. Each colour field is
// widened to 8 bits by repeating its bits MSB first, so full-scale fields
// map to 0xFF and zero fields map to 0x00.
module anton_neopixel_rgb332_expand (
    input  logic [7:0]  rgb332,
    output logic [23:0] grb
);

    logic [2:0] red_s;
    logic [2:0] green_s;
    logic [1:0] blue_s;

    assign red_s   = rgb332[7:5];
    assign green_s = rgb332[4:2];
    assign blue_s  = rgb332[1:0];

    assign grb = {green_s, green_s, green_s[2:1],
                  red_s,   red_s,   red_s[2:1],
                  blue_s,  blue_s,  blue_s,  blue_s};

endmodule

// File: rtl/anton_neopixel_pixel_serializer.sv
// NeoPixel pixel serializer: prefetches the next pixel from the byte pixel
// buffer (double-buffered), hands it over at pixel boundaries and shapes
// each GRB bit as an 8-tick high/low pattern on neoData.
module anton_neopixel_pixel_serializer
    import anton_neopixel_pixel_serializer_pkg::*;
#(
    parameter int  BUFFER_END  = BUFFER_END_DEFAULT,
    parameter int  T0H_TICKS   = T0H_TICKS_DEFAULT,
    parameter int  T1H_TICKS   = T1H_TICKS_DEFAULT,
    localparam int BUFFER_BITS = $clog2(BUFFER_END + 1)
) (
    input  logic                   clk6_4mhz,
    input  logic                   rstn,
    input  logic                   regCtrl32bit,
    input  logic [BUFFER_BITS-1:0] pixelIndexMax,
    input  logic                   streamOutput,
    input  logic                   streamReset,
    input  logic                   streamBitOf,
    input  logic [2:0]             bitPatternIndex,
    input  logic [4:0]             pixelBitIndex,
    input  logic                   initSlow,
    output logic [BUFFER_BITS-1:0] ramAddr,
    output logic                   ramRd,
    input  logic [7:0]             ramRdata,
    output logic                   neoData,
    output logic                   underrun
);

    localparam logic [BUFFER_BITS-1:0] ADDR_MASK_8  = {BUFFER_BITS{1'b1}};
    localparam logic [BUFFER_BITS-1:0] ADDR_MASK_32 = {BUFFER_BITS{1'b1}} << 2'd2;
    localparam logic [BUFFER_BITS-1:0] ADDR_STEP_8  = BUFFER_BITS'(1);
    localparam logic [BUFFER_BITS-1:0] ADDR_STEP_32 = BUFFER_BITS'(4);
    localparam logic [2:0]             T0H_HIGH     = 3'(T0H_TICKS);
    localparam logic [2:0]             T1H_HIGH     = 3'(T1H_TICKS);

    fetchState_e            fetchState_r;
    fetchState_e            fetchStateNext_s;
    logic [BUFFER_BITS-1:0] fetchAddr_r;
    logic [BUFFER_BITS-1:0] fetchLimit_r;
    logic                   fetchMode32_r;
    logic [7:0]             byteG_r;
    logic [7:0]             byteR_r;
    logic [23:0]            nextPixel_r;
    logic                   nextValid_r;
    logic [23:0]            curPixel_r;
    logic                   sawReset_r;
    logic [BUFFER_BITS-1:0] ramAddr_r;
    logic                   ramRd_r;
    logic                   neoData_r;
    logic                   underrun_r;

    logic                   mode32_s;
    logic [BUFFER_BITS-1:0] addrMask_s;
    logic [BUFFER_BITS-1:0] readBase_s;
    logic [BUFFER_BITS-1:0] limitBase_s;
    logic [BUFFER_BITS-1:0] fetchAddrNext_s;
    logic [BUFFER_BITS-1:0] ramAddrNext_s;
    logic                   ramRdNext_s;
    logic [23:0]            expandedPixel_s;
    logic [23:0]            donePixel_s;
    logic                   handover_s;
    logic                   frameStart_s;
    logic [23:0]            loadPixel_s;
    logic [23:0]            patternPixel_s;
    logic [2:0]             highTicks_s;
    logic                   neoDataNext_s;

    anton_neopixel_rgb332_expand u_expand (
        .rgb332 (ramRdata),
        .grb    (expandedPixel_s)
    );

    // Fetch FSM next state, read strobe/address and the post-fetch address step.
    always_comb begin
        fetchStateNext_s = fetchState_r;
        if (initSlow) begin
            fetchStateNext_s = FETCH_IDLE;
        end else begin
            case (fetchState_r)
                FETCH_IDLE: begin
                    if (!nextValid_r) begin
                        fetchStateNext_s = FETCH_RD0;
                    end else begin
                        fetchStateNext_s = FETCH_IDLE;
                    end
                end
                FETCH_RD0: begin
                    if (fetchMode32_r) begin
                        fetchStateNext_s = FETCH_RD1;
                    end else begin
                        fetchStateNext_s = FETCH_DONE;
                    end
                end
                FETCH_RD1: fetchStateNext_s = FETCH_RD2;
                FETCH_RD2: fetchStateNext_s = FETCH_DONE;
                FETCH_DONE: fetchStateNext_s = FETCH_IDLE;
                default: fetchStateNext_s = FETCH_IDLE;
            endcase
        end

        // Mode tracks the control register while idle and is frozen once a fetch starts.
        if (fetchState_r == FETCH_IDLE) begin
            mode32_s = regCtrl32bit;
        end else begin
            mode32_s = fetchMode32_r;
        end
        if (mode32_s) begin
            addrMask_s = ADDR_MASK_32;
        end else begin
            addrMask_s = ADDR_MASK_8;
        end
        readBase_s  = fetchAddr_r & addrMask_s;
        limitBase_s = fetchLimit_r & addrMask_s;

        if (readBase_s >= limitBase_s) begin
            fetchAddrNext_s = {BUFFER_BITS{1'b0}};
        end else if (mode32_s) begin
            fetchAddrNext_s = readBase_s + ADDR_STEP_32;
        end else begin
            fetchAddrNext_s = readBase_s + ADDR_STEP_8;
        end

        ramRdNext_s   = 1'b0;
        ramAddrNext_s = ramAddr_r;
        case (fetchStateNext_s)
            FETCH_RD0: begin
                ramRdNext_s   = 1'b1;
                ramAddrNext_s = readBase_s;
            end
            FETCH_RD1: begin
                ramRdNext_s   = 1'b1;
                ramAddrNext_s = readBase_s + BUFFER_BITS'(1);
            end
            FETCH_RD2: begin
                ramRdNext_s   = 1'b1;
                ramAddrNext_s = readBase_s + BUFFER_BITS'(2);
            end
            default: begin
                ramRdNext_s   = 1'b0;
                ramAddrNext_s = ramAddr_r;
            end
        endcase

        // The last byte arrives in DONE straight from the read port.
        if (fetchMode32_r) begin
            donePixel_s = {byteG_r, byteR_r, ramRdata};
        end else begin
            donePixel_s = expandedPixel_s;
        end
    end

    // Handover strobes and the pixel word feeding the bit-pattern comparator.
    always_comb begin
        handover_s   = streamBitOf || (streamOutput && sawReset_r);
        // On the first transmit tick of a frame the indexes already address the new pixel.
        frameStart_s = streamOutput && sawReset_r && !streamBitOf && !initSlow;
        if (nextValid_r) begin
            loadPixel_s = nextPixel_r;
        end else begin
            loadPixel_s = 24'd0;
        end
        if (frameStart_s) begin
            patternPixel_s = loadPixel_s;
        end else begin
            patternPixel_s = curPixel_r;
        end
        if (pixelBitAt(patternPixel_s, pixelBitIndex)) begin
            highTicks_s = T1H_HIGH;
        end else begin
            highTicks_s = T0H_HIGH;
        end
        neoDataNext_s = streamOutput && !streamReset && (bitPatternIndex < highTicks_s);
    end

    // Fetch state register and registered read port outputs.
    always_ff @(posedge clk6_4mhz) begin
        if (!rstn) begin
            fetchState_r <= FETCH_IDLE;
            ramRd_r      <= 1'b0;
            ramAddr_r    <= {BUFFER_BITS{1'b0}};
        end else begin
            fetchState_r <= fetchStateNext_s;
            ramRd_r      <= ramRdNext_s;
            ramAddr_r    <= ramAddrNext_s;
        end
    end

    // Prefetch datapath: byte capture, next-pixel buffer and fetch address stepping.
    always_ff @(posedge clk6_4mhz) begin
        if (!rstn) begin
            fetchAddr_r   <= {BUFFER_BITS{1'b0}};
            fetchLimit_r  <= {BUFFER_BITS{1'b0}};
            fetchMode32_r <= 1'b0;
            byteG_r       <= 8'd0;
            byteR_r       <= 8'd0;
            nextPixel_r   <= 24'd0;
            nextValid_r   <= 1'b0;
        end else if (initSlow) begin
            fetchAddr_r <= {BUFFER_BITS{1'b0}};
            nextValid_r <= 1'b0;
        end else begin
            case (fetchState_r)
                FETCH_IDLE: begin
                    fetchMode32_r <= regCtrl32bit;
                    fetchLimit_r  <= pixelIndexMax;
                end
                FETCH_RD1: byteG_r <= ramRdata;
                FETCH_RD2: byteR_r <= ramRdata;
                default: begin
                    byteG_r <= byteG_r;
                end
            endcase
            if (fetchState_r == FETCH_DONE) begin
                nextPixel_r <= donePixel_s;
                nextValid_r <= 1'b1;
                fetchAddr_r <= fetchAddrNext_s;
            end else if (handover_s) begin
                nextValid_r <= 1'b0;
            end
        end
    end

    // Pixel handover into the shift pixel, sticky underrun and frame-start tracking.
    always_ff @(posedge clk6_4mhz) begin
        if (!rstn) begin
            curPixel_r <= 24'd0;
            underrun_r <= 1'b0;
            sawReset_r <= 1'b0;
        end else begin
            if (streamReset) begin
                sawReset_r <= 1'b1;
            end else if (streamOutput) begin
                sawReset_r <= 1'b0;
            end
            if (handover_s && !initSlow) begin
                curPixel_r <= loadPixel_s;
                if (!nextValid_r) begin
                    underrun_r <= 1'b1;
                end
            end
        end
    end

    // Registered NeoPixel data pin.
    always_ff @(posedge clk6_4mhz) begin
        if (!rstn) begin
            neoData_r <= 1'b0;
        end else begin
            neoData_r <= neoDataNext_s;
        end
    end

    assign ramAddr  = ramAddr_r;
    assign ramRd    = ramRd_r;
    assign neoData  = neoData_r;
    assign underrun = underrun_r;

endmodule

// File: tb/tb_anton_neopixel_pixel_serializer.sv
// Directed bench for the NeoPixel pixel serializer: a behavioural pixel
// buffer with 1-cycle read latency, a stream-logic stand-in driving the
// tick/bit indexes, and a queue of expected neoData values.
module tb_anton_neopixel_pixel_serializer;

    localparam int BUFFER_END  = 15;
    localparam int BUFFER_BITS = $clog2(BUFFER_END + 1);

    logic                   clk6_4mhz = 1'b0;
    logic                   rstn;
    logic                   regCtrl32bit;
    logic [BUFFER_BITS-1:0] pixelIndexMax;
    logic                   streamOutput;
    logic                   streamReset;
    logic                   streamBitOf;
    logic [2:0]             bitPatternIndex;
    logic [4:0]             pixelBitIndex;
    logic                   initSlow;
    logic [BUFFER_BITS-1:0] ramAddr;
    logic                   ramRd;
    logic [7:0]             ramRdata;
    logic                   neoData;
    logic                   underrun;

    logic [7:0]             mem [0:BUFFER_END];
    logic [BUFFER_BITS-1:0] readLog [$];
    logic                   expQ [$];
    int                     expAddrQ [$];
    int                     checkCount = 0;
    int                     passCount  = 0;
    int                     failCount  = 0;

    anton_neopixel_pixel_serializer #(.BUFFER_END(BUFFER_END)) dut (
        .clk6_4mhz       (clk6_4mhz),
        .rstn            (rstn),
        .regCtrl32bit    (regCtrl32bit),
        .pixelIndexMax   (pixelIndexMax),
        .streamOutput    (streamOutput),
        .streamReset     (streamReset),
        .streamBitOf     (streamBitOf),
        .bitPatternIndex (bitPatternIndex),
        .pixelBitIndex   (pixelBitIndex),
        .initSlow        (initSlow),
        .ramAddr         (ramAddr),
        .ramRd           (ramRd),
        .ramRdata        (ramRdata),
        .neoData         (neoData),
        .underrun        (underrun)
    );

    always #5 clk6_4mhz = ~clk6_4mhz;

    // Pixel buffer: data for a strobed address appears after the next edge.
    always @(posedge clk6_4mhz) begin
        if (ramRd) begin
            ramRdata <= mem[ramAddr];
            readLog.push_back(ramAddr);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference RGB332 expansion written as per-bit replication.
    function automatic logic [23:0] expand332(input logic [7:0] v);
        logic [7:0] g8;
        logic [7:0] r8;
        logic [7:0] b8;
        for (int i = 0; i < 8; i++) begin
            r8[7-i] = v[7 - (i % 3)];
            g8[7-i] = v[4 - (i % 3)];
            b8[7-i] = v[1 - (i % 2)];
        end
        return {g8, r8, b8};
    endfunction

    task automatic tick(input logic so, input logic sr, input int b, input int t,
                        input logic bof, input logic init, input logic expNeo, input string tag);
        @(negedge clk6_4mhz);
        streamOutput    = so;
        streamReset     = sr;
        pixelBitIndex   = 5'(b);
        bitPatternIndex = 3'(t);
        streamBitOf     = bof;
        initSlow        = init;
        expQ.push_back(expNeo);
        @(posedge clk6_4mhz);
        #1;
        check(tag, 32'(neoData), 32'(expQ.pop_front()));
    endtask

    task automatic gap(input int n, input logic initFirst);
        for (int i = 0; i < n; i++) begin
            tick(1'b0, 1'b1, 0, 0, 1'b0, initFirst && (i == 0), 1'b0, "gap_neo");
        end
    endtask

    task automatic sendPixel(input logic [23:0] px, input int initAt, input logic lastInFrame, input string tag);
        for (int b = 0; b < 24; b++) begin
            for (int t = 0; t < 8; t++) begin
                int   high;
                logic expNeo;
                high   = px[23-b] ? 6 : 3;
                expNeo = (t < high);
                tick(1'b1, 1'b0, b, t, (b == 23) && (t == 7) && !lastInFrame,
                     (b * 8 + t) == initAt, expNeo, tag);
            end
        end
    endtask

    task automatic checkReads(input string tag);
        check({tag, "_len"}, 32'(readLog.size() >= expAddrQ.size()), 32'd1);
        for (int i = 0; i < expAddrQ.size(); i++) begin
            if (i < readLog.size()) begin
                check(tag, 32'(readLog[i]), 32'(expAddrQ[i]));
            end
        end
        expAddrQ.delete();
    endtask

    initial begin
        int  bad;
        logic found;
        for (int i = 0; i <= BUFFER_END; i++) mem[i] = 8'h00;
        mem[0] = 8'hFF; mem[1] = 8'h00; mem[2] = 8'hA5; mem[3] = 8'hEE;
        mem[4] = 8'h12; mem[5] = 8'h34; mem[6] = 8'h56; mem[7] = 8'hEE;
        ramRdata = 8'h00;
        rstn = 1'b0; regCtrl32bit = 1'b1; pixelIndexMax = 4'd7;
        streamOutput = 1'b0; streamReset = 1'b0; streamBitOf = 1'b0;
        bitPatternIndex = 3'd0; pixelBitIndex = 5'd0; initSlow = 1'b0;

        // Reset state
        repeat (3) @(posedge clk6_4mhz);
        #1;
        check("rst_neo", 32'(neoData), 32'd0);
        check("rst_rd", 32'(ramRd), 32'd0);
        check("rst_addr", 32'(ramAddr), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        @(negedge clk6_4mhz);
        rstn = 1'b1;

        // 32-bit mode, limit 7: pixels alternate between bytes 0 and 4 over 3 frames
        gap(20, 1'b0);
        for (int f = 0; f < 3; f++) begin
            sendPixel(24'hFF00A5, -1, 1'b0, "px32_a");
            sendPixel(24'h123456, -1, 1'b1, "px32_b");
            gap(20, 1'b0);
        end
        check("u32_underrun", 32'(underrun), 32'd0);
        expAddrQ = '{0, 1, 2, 4, 5, 6, 0};
        checkReads("rd32_addr");
        bad = 0;
        foreach (readLog[i]) if (readLog[i] == 4'd3 || readLog[i] == 4'd7) bad++;
        check("rd32_skip", 32'(bad), 32'd0);

        // 8-bit mode RGB332, limit 1
        regCtrl32bit = 1'b0; pixelIndexMax = 4'd1;
        mem[0] = 8'hE7; mem[1] = 8'hE3;
        readLog.delete();
        gap(1, 1'b1);
        gap(10, 1'b0);
        sendPixel(24'h24FFFF, -1, 1'b0, "px8_a");
        sendPixel(expand332(8'hE3), -1, 1'b1, "px8_b");
        expAddrQ = '{0, 1, 0};
        checkReads("rd8_addr");
        check("u8_underrun", 32'(underrun), 32'd0);

        // Underrun: re-arm one tick before the boundary, next pixel sends all zeros
        gap(10, 1'b0);
        sendPixel(24'h24FFFF, 190, 1'b0, "ur_a");
        sendPixel(24'h000000, -1, 1'b1, "ur_zero");
        check("ur_set", 32'(underrun), 32'd1);
        gap(5, 1'b0);
        check("ur_sticky", 32'(underrun), 32'd1);

        // Reset during RD1 of a 32-bit fetch
        regCtrl32bit = 1'b1; pixelIndexMax = 4'd7;
        mem[0] = 8'hFF; mem[1] = 8'h00; mem[2] = 8'hA5;
        gap(1, 1'b1);
        initSlow = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk6_4mhz);
            #1;
            if (ramRd && ramAddr == 4'd1) begin
                found = 1'b1;
                break;
            end
        end
        check("rd1_seen", 32'(found), 32'd1);
        rstn = 1'b0;
        @(posedge clk6_4mhz);
        #1;
        check("mid_rst_rd", 32'(ramRd), 32'd0);
        check("mid_rst_neo", 32'(neoData), 32'd0);
        check("mid_rst_addr", 32'(ramAddr), 32'd0);
        check("mid_rst_underrun", 32'(underrun), 32'd0);
        readLog.delete();
        @(negedge clk6_4mhz);
        rstn = 1'b1;

        // Long latch gap, then the first transmit tick must already carry pixel 0
        gap(1959, 1'b0);
        expAddrQ = '{0, 1, 2};
        checkReads("rst_refetch");
        sendPixel(24'hFF00A5, -1, 1'b1, "post_rst");
        check("post_underrun", 32'(underrun), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
